// File: rtl/jtag_ir_dr_if.sv
// TAP-side signal bundle for jtag_ir_dr: serial data plus the TAP controller's
// per-state strobes, and the TDO driver outputs returned to the pad.
interface jtag_ir_dr_if;
  logic tdi;
  logic tap_reset;
  logic capture_ir;
  logic shift_ir;
  logic update_ir;
  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic tdo;
  logic tdo_en;

  modport master (
    output tdi, tap_reset, capture_ir, shift_ir, update_ir,
           capture_dr, shift_dr, update_dr,
    input  tdo, tdo_en
  );

  modport slave (
    input  tdi, tap_reset, capture_ir, shift_ir, update_ir,
           capture_dr, shift_dr, update_dr,
    output tdo, tdo_en
  );
endinterface

// File: rtl/jtag_ir_dr.sv
// JTAG instruction register, BYPASS/IDCODE/USER data chains and negedge TDO driver.
// Define JTAG_IDCODE_EN to include the IDCODE instruction and its 32-bit chain.
module jtag_ir_dr #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          USER_WIDTH = 8
) (
  input  logic                  tck,
  input  logic                  reset_n,
  jtag_ir_dr_if.slave           tap,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  user_update,
  output logic [IR_WIDTH-1:0]   ir_out
);

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAPT   = IR_WIDTH'(1);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] RST_IR    = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_IR    = OP_BYPASS;
`endif

  logic [IR_WIDTH-1:0]   ir_shift;
  logic                  bypass;
  logic [USER_WIDTH-1:0] user_shift;
  logic [USER_WIDTH-1:0] user_nxt;
  logic                  sel_user;
  logic                  sel_byp;
  logic                  dr0;

  assign sel_user = (ir_out == OP_USER);

  // IR: capture > shift > update; tap_reset overrides any pending update.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      ir_shift <= '0;
      ir_out   <= RST_IR;
    end else begin
      if (tap.capture_ir)
        ir_shift <= IR_CAPT;
      else if (tap.shift_ir)
        ir_shift <= {tap.tdi, ir_shift[IR_WIDTH-1:1]};

      if (tap.tap_reset)
        ir_out <= RST_IR;
      else if (tap.update_ir && !tap.capture_ir && !tap.shift_ir)
        ir_out <= ir_shift;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic        sel_id;
  logic [31:0] id_shift;

  assign sel_id  = (ir_out == OP_IDCODE);
  assign sel_byp = !sel_user && !sel_id;
  assign dr0     = sel_user ? user_shift[0] : (sel_id ? id_shift[0] : bypass);

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n)
      id_shift <= '0;
    else if (sel_id) begin
      if (tap.capture_dr)
        id_shift <= IDCODE_VAL;
      else if (tap.shift_dr)
        id_shift <= {tap.tdi, id_shift[31:1]};
    end
  end
`else
  assign sel_byp = !sel_user;
  assign dr0     = sel_user ? user_shift[0] : bypass;
`endif

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n)
      bypass <= 1'b0;
    else if (sel_byp) begin
      if (tap.capture_dr)
        bypass <= 1'b0;
      else if (tap.shift_dr)
        bypass <= tap.tdi;
    end
  end

  generate
    if (USER_WIDTH == 1) begin : g_user_w1
      assign user_nxt = tap.tdi;
    end else begin : g_user_wn
      assign user_nxt = {tap.tdi, user_shift[USER_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      user_shift  <= '0;
      user_out    <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (sel_user) begin
        if (tap.capture_dr)
          user_shift <= user_in;
        else if (tap.shift_dr)
          user_shift <= user_nxt;
        else if (tap.update_dr) begin
          user_out    <= user_shift;
          user_update <= 1'b1;
        end
      end
    end
  end

  // Falling-edge launch gives the external sampler a half-cycle of hold margin.
  always_ff @(negedge tck or negedge reset_n) begin
    if (!reset_n) begin
      tap.tdo    <= 1'b0;
      tap.tdo_en <= 1'b0;
    end else begin
      if (tap.shift_ir)
        tap.tdo <= ir_shift[0];
      else if (tap.shift_dr)
        tap.tdo <= dr0;
      tap.tdo_en <= tap.shift_ir | tap.shift_dr;
    end
  end

endmodule

// File: tb/tb_jtag_ir_dr.sv
// Scoreboard bench for jtag_ir_dr: stimulus queues expected TDO bits and USER
// updates; a monitor pops and compares whenever tdo_en or user_update is seen.
module tb_jtag_ir_dr;
  localparam logic [31:0] IDC = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'h1;
`else
  localparam logic [3:0] RST_IR = 4'hF;
`endif
  localparam logic [3:0] IRC = 4'b0001;

  logic       tck = 1'b0;
  logic       reset_n;
  logic [7:0] user_in;
  logic [7:0] user_out;
  logic       user_update;
  logic [3:0] ir_out;

  jtag_ir_dr_if jif ();

  jtag_ir_dr #(.IR_WIDTH(4), .IDCODE_VAL(IDC), .USER_WIDTH(8)) dut (
    .tck(tck), .reset_n(reset_n), .tap(jif.slave),
    .user_in(user_in), .user_out(user_out),
    .user_update(user_update), .ir_out(ir_out)
  );

  always #5 tck = ~tck;

  int total = 0;
  int bad   = 0;
  logic       tq[$];
  logic [7:0] uq[$];
  logic       tdo_e;
  logic [7:0] uo_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Monitor: samples mid low phase, well away from both tck edges.
  initial forever begin
    @(negedge tck);
    #2;
    if (jif.tdo_en === 1'b1) begin
      total++;
      if (tq.size() == 0) begin
        bad++;
        $display("FAIL tdo_unexpected act=%b req=none", jif.tdo);
      end else begin
        tdo_e = tq.pop_front();
        if (jif.tdo !== tdo_e) begin
          bad++;
          $display("FAIL tdo_bit act=%b req=%b", jif.tdo, tdo_e);
        end
      end
    end
    if (user_update === 1'b1) begin
      total++;
      if (uq.size() == 0) begin
        bad++;
        $display("FAIL user_update_unexpected act=%h req=none", user_out);
      end else begin
        uo_e = uq.pop_front();
        if (user_out !== uo_e) begin
          bad++;
          $display("FAIL user_out_at_update act=%h req=%h", user_out, uo_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic ir_scan(input logic [3:0] val, input bit tr);
    jif.capture_ir = 1'b1;
    step();
    jif.capture_ir = 1'b0;
    jif.shift_ir   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      jif.tdi = val[i];
      tq.push_back(IRC[i]);
      step();
    end
    jif.shift_ir  = 1'b0;
    jif.tdi       = 1'b0;
    jif.update_ir = 1'b1;
    jif.tap_reset = tr;
    step();
    jif.update_ir = 1'b0;
    jif.tap_reset = 1'b0;
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] dexp, input bit upd);
    jif.capture_dr = 1'b1;
    step();
    jif.capture_dr = 1'b0;
    jif.shift_dr   = 1'b1;
    for (int i = 0; i < n; i++) begin
      jif.tdi = din[i];
      tq.push_back(dexp[i]);
      step();
    end
    jif.shift_dr = 1'b0;
    jif.tdi      = 1'b0;
    if (upd) begin
      jif.update_dr = 1'b1;
      step();
      jif.update_dr = 1'b0;
    end
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    user_in = 8'hA5;
    jif.tdi = 1'b0; jif.tap_reset = 1'b0;
    jif.capture_ir = 1'b0; jif.shift_ir = 1'b0; jif.update_ir = 1'b0;
    jif.capture_dr = 1'b0; jif.shift_dr = 1'b0; jif.update_dr = 1'b0;
    repeat (3) @(posedge tck);
    #1 reset_n = 1'b1;
    chk("rst_ir_out", 32'(ir_out), 32'(RST_IR));
    chk("rst_tdo", 32'(jif.tdo), 32'd0);
    chk("rst_tdo_en", 32'(jif.tdo_en), 32'd0);
    chk("rst_user_out", 32'(user_out), 32'd0);
    chk("rst_user_update", 32'(user_update), 32'd0);

    // Reset instruction drives the first DR scan.
`ifdef JTAG_IDCODE_EN
    dr_scan(32, 64'd0, {32'd0, IDC}, 1'b0);
`else
    dr_scan(5, 64'h0D, 64'h1A, 1'b0);
`endif

    ir_scan(4'h2, 1'b0);
    chk("ir_user", 32'(ir_out), 32'h2);
    ir_scan(4'hF, 1'b0);
    chk("ir_bypass", 32'(ir_out), 32'hF);

    // BYPASS: tdi 1,0,1,1,0 -> tdo 0,1,0,1,1; update_dr must not touch USER.
    dr_scan(5, 64'h0D, 64'h1A, 1'b1);
    chk("bypass_user_out_held", 32'(user_out), 32'h0);

    ir_scan(4'h2, 1'b0);
    user_in = 8'hA5;
    uq.push_back(8'h3C);
    dr_scan(8, 64'h3C, 64'hA5, 1'b1);
    chk("user_out_3c", 32'(user_out), 32'h3C);
    chk("user_update_low", 32'(user_update), 32'd0);

    user_in = 8'h0F;
    uq.push_back(8'hC3);
    dr_scan(8, 64'hC3, 64'h0F, 1'b1);
    chk("user_out_c3", 32'(user_out), 32'hC3);

    // Undefined opcode behaves as BYPASS.
    ir_scan(4'h5, 1'b0);
    chk("ir_op5", 32'(ir_out), 32'h5);
    dr_scan(5, 64'h0D, 64'h1A, 1'b1);
    chk("op5_user_out_held", 32'(user_out), 32'hC3);

    ir_scan(4'h1, 1'b0);
    chk("ir_op1", 32'(ir_out), 32'h1);
`ifdef JTAG_IDCODE_EN
    dr_scan(32, 64'd0, {32'd0, IDC}, 1'b0);
`else
    dr_scan(5, 64'h0B, 64'h16, 1'b0);
`endif

    // tap_reset wins over a simultaneous update_ir.
    ir_scan(4'h2, 1'b1);
    chk("tap_reset_override", 32'(ir_out), 32'(RST_IR));

    // Abort a USER scan with reset_n mid-shift.
    ir_scan(4'h2, 1'b0);
    chk("ir_user_again", 32'(ir_out), 32'h2);
    user_in = 8'h5A;
    jif.capture_dr = 1'b1;
    step();
    jif.capture_dr = 1'b0;
    jif.shift_dr   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jif.tdi = 1'b1;
      tq.push_back(user_in[i]);
      step();
    end
    reset_n       = 1'b0;
    jif.shift_dr  = 1'b0;
    jif.tdi       = 1'b0;
    jif.update_dr = 1'b1;
    step();
    chk("abort_user_out_in_reset", 32'(user_out), 32'h0);
    jif.update_dr = 1'b0;
    reset_n       = 1'b1;
    step();
    chk("abort_user_out", 32'(user_out), 32'h0);
    chk("abort_ir_out", 32'(ir_out), 32'(RST_IR));
    chk("abort_tdo", 32'(jif.tdo), 32'd0);
    chk("abort_tdo_en", 32'(jif.tdo_en), 32'd0);

    repeat (3) step();
    chk("tdo_queue_drained", 32'(tq.size()), 32'd0);
    chk("user_queue_drained", 32'(uq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
